// File: rtl/ysyx_22040386_pc_unit.sv
// rtl/ysyx_22040386_pc_unit.sv - architectural PC, fetch offer handshake, next-PC select, minstret
// Optional misaligned-target halt enabled by defining PC_MISALIGN_CHK_EN.
`timescale 1ns/1ps
module ysyx_22040386_pc_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    output logic [XLEN-1:0] pc_o,
    input  logic            commit_i,
    input  logic            branch_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] csr_dnpc_i,
    output logic [XLEN-1:0] instret_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        BOOT        = 2'd0,
        OFFER       = 2'd1,
        WAIT_COMMIT = 2'd2,
        HALT        = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] CNT_STEP  = XLEN'(1);

    state_t          state;
    logic [XLEN-1:0] next_pc;

    // Trap redirect wins over branch; branch targets always drop bit 0 (jalr semantics).
    always_comb begin
        next_pc = pc_o + PC_STEP;
        if (trap_i) begin
            next_pc = csr_dnpc_i;
        end else if (branch_i) begin
            next_pc = {branch_target_i[XLEN-1:1], 1'b0};
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    logic misalign_q;
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_o       <= RESET_PC;
            pc_valid_o <= 1'b0;
            instret_o  <= '0;
`ifdef PC_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state      <= OFFER;
                    pc_valid_o <= 1'b1;
                end
                OFFER: begin
                    if (pc_valid_o && pc_ready_i) begin
                        state      <= WAIT_COMMIT;
                        pc_valid_o <= 1'b0;
                    end
                end
                WAIT_COMMIT: begin
                    if (commit_i) begin
                        pc_o      <= next_pc;
                        instret_o <= instret_o + CNT_STEP;
`ifdef PC_MISALIGN_CHK_EN
                        if (next_pc[1]) begin
                            misalign_q <= 1'b1;
                            state      <= HALT;
                            pc_valid_o <= 1'b0;
                        end else begin
                            state      <= OFFER;
                            pc_valid_o <= 1'b1;
                        end
`else
                        state      <= OFFER;
                        pc_valid_o <= 1'b1;
`endif
                    end
                end
                HALT: begin
                    pc_valid_o <= 1'b0;
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
